// File: rtl/lsq_mem_drain_if.sv
// Shared payload types and the handshake bundle between the LSQ drain and its environment.

package lsq_mem_drain_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PD_W  = 6;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned ROB_W = 5;

  // LSQ entry as produced by dispatch/AGU; address and store data already resolved
  typedef struct packed {
    logic             sw_sh_signal;
    logic [PD_W-1:0]  pd;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  ps2_data;
  } lsq_entry_t;

  // Writeback to ROB/PRF plus the queue-ready back-pressure flag
  typedef struct packed {
    logic [PD_W-1:0]  p_mem;
    logic             fu_mem_done;
    logic             fu_mem_ready;
    logic [ROB_W-1:0] rob_fu_mem;
    logic [XLEN-1:0]  data;
  } mem_data_t;
endpackage

interface lsq_mem_drain_if;
  import lsq_mem_drain_pkg::*;

  logic             enq_valid;
  lsq_entry_t       enq_data;
  logic             store_commit;
  logic             flush;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_we;
  logic [XLEN-1:0]  mem_req_addr;
  logic [XLEN-1:0]  mem_req_wdata;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_rdata;
  mem_data_t        mem_out;

  // master: the drain (memory-request master, writeback source)
  modport master (
    input  enq_valid, enq_data, store_commit, flush,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_out
  );

  // slave: dispatch, ROB and data memory around the drain
  modport slave (
    output enq_valid, enq_data, store_commit, flush,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_out
  );
endinterface

// File: rtl/lsq_mem_drain.sv
// In-order LSQ buffer that drains its head entry to data memory, one access at a time.

module lsq_mem_drain
  import lsq_mem_drain_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  lsq_mem_drain_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, ST_HOLD, ST_REQ, ST_WAIT, DISCARD
  } state_e;

  lsq_entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [PTR_W-1:0]       head_d, tail_d, head_inc;
  logic [CNT_W-1:0]       count_q, count_d;
  state_e                 state_q;
  logic                   req_valid_q, req_we_q;
  logic [XLEN-1:0]        req_addr_q, req_wdata_q;
  mem_data_t              out_q;

  lsq_entry_t             head_e;
  logic                   enq_fire, pop, head_cmt;
  logic [XLEN-1:0]        head_addr;
  logic                   unused_head_bits;

  // Queue bookkeeping: enqueue/pop, and flush squashing everything but a committed head
  always_comb begin
    head_e    = buf_q[head_q];
    head_addr = {head_e.addr[XLEN-1:2], 2'b00};
    enq_fire  = bus.enq_valid && (count_q != CNT_W'(DEPTH)) && !bus.flush;
    pop       = bus.mem_rsp_valid && ((state_q == LD_WAIT) || (state_q == ST_WAIT));
    head_cmt  = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                ((state_q == ST_HOLD) && bus.store_commit);
    head_inc  = head_q + PTR_W'(1);
    head_d    = pop ? head_inc : head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (bus.flush) begin
      if (head_cmt) begin
        tail_d  = head_inc;
        count_d = pop ? CNT_W'(0) : CNT_W'(1);
      end else begin
        tail_d  = head_d;
        count_d = CNT_W'(0);
      end
    end else begin
      tail_d  = enq_fire ? (tail_q + PTR_W'(1)) : tail_q;
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(pop);
    end
  end

  assign unused_head_bits = ^{head_e.addr[1:0], head_e.rob_tag[TAG_W-1:ROB_W]};

  // Entry storage; contents only matter where count marks them live
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      buf_q[tail_q] <= bus.enq_data;
    end
  end

  // Pointers, head-entry access FSM, memory request and writeback registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      req_valid_q   <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      out_q         <= '0;
      out_q.fu_mem_ready <= 1'b1;
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      out_q.fu_mem_ready <= (count_d != CNT_W'(DEPTH));
      out_q.fu_mem_done  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != CNT_W'(0)) begin
            if (!head_e.sw_sh_signal) begin
              if (!bus.flush) begin
                state_q     <= LD_REQ;
                req_valid_q <= 1'b1;
                req_we_q    <= 1'b0;
                req_addr_q  <= head_addr;
                req_wdata_q <= '0;
              end
            end else begin
              // store-done report goes out even if this entry is being squashed
              out_q.fu_mem_done <= 1'b1;
              out_q.p_mem       <= '0;
              out_q.rob_fu_mem  <= head_e.rob_tag[ROB_W-1:0];
              out_q.data        <= '0;
              if (!bus.flush) begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        LD_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= bus.flush ? DISCARD : LD_WAIT;
          end else if (bus.flush) begin
            req_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        LD_WAIT: begin
          if (bus.mem_rsp_valid) begin
            out_q.fu_mem_done <= 1'b1;
            out_q.p_mem       <= head_e.pd;
            out_q.rob_fu_mem  <= head_e.rob_tag[ROB_W-1:0];
            out_q.data        <= bus.mem_rsp_rdata;
            state_q           <= IDLE;
          end else if (bus.flush) begin
            state_q <= DISCARD;
          end
        end
        ST_HOLD: begin
          if (bus.store_commit) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b1;
            req_addr_q  <= head_addr;
            req_wdata_q <= head_e.ps2_data;
          end else if (bus.flush) begin
            state_q <= IDLE;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rsp_valid) begin
            state_q <= IDLE;
          end
        end
        DISCARD: begin
          if (bus.mem_rsp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_out       = out_q;

endmodule
